// File: rtl/hfrv_mem_arbiter_pkg.sv
// Shared types and bus widths for the HF-RISCV memory-port arbiter.
package hfrv_mem_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_CPU    = 2'd0,
    ARB_SWITCH = 2'd1,
    ARB_AUX    = 2'd2
  } arb_state_t;
endpackage

// File: rtl/hfrv_mem_arbiter_if.sv
// Bundle of CPU, aux-master and shared-memory signals around the arbiter.
interface hfrv_mem_arbiter_if;
  import hfrv_mem_arbiter_pkg::*;

  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data_write;
  logic [BE_W-1:0]   cpu_data_we;
  logic [DATA_W-1:0] cpu_data_read;
  logic              stall;
  logic              aux_req;
  logic [ADDR_W-1:0] aux_address;
  logic [DATA_W-1:0] aux_data_write;
  logic [BE_W-1:0]   aux_data_we;
  logic              aux_gnt;
  logic [DATA_W-1:0] aux_data_read;
  logic              aux_rvalid;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_write;
  logic [BE_W-1:0]   mem_data_we;
  logic [DATA_W-1:0] mem_data_read;

  modport slave (
    input  cpu_address, cpu_data_write, cpu_data_we,
    input  aux_req, aux_address, aux_data_write, aux_data_we,
    input  mem_data_read,
    output cpu_data_read, stall, aux_gnt, aux_data_read, aux_rvalid,
    output mem_address, mem_data_write, mem_data_we
  );

  modport master (
    output cpu_address, cpu_data_write, cpu_data_we,
    output aux_req, aux_address, aux_data_write, aux_data_we,
    output mem_data_read,
    input  cpu_data_read, stall, aux_gnt, aux_data_read, aux_rvalid,
    input  mem_address, mem_data_write, mem_data_we
  );
endinterface

// File: rtl/hfrv_mem_arbiter.sv
// Shares the single HF-RISCV memory port between the CPU and one aux master,
// with bounded aux bursts followed by a guaranteed CPU window.
module hfrv_mem_arbiter
  import hfrv_mem_arbiter_pkg::*;
#(
  parameter int AUX_MAX_BURST = 8,
  parameter int CPU_MIN_SLOTS = 4
) (
  input  logic              clk,
  input  logic              reset,
  hfrv_mem_arbiter_if.slave bus
);

  localparam int BEAT_W = $clog2(AUX_MAX_BURST) + 1;
  localparam int SLOT_W = $clog2(CPU_MIN_SLOTS) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(AUX_MAX_BURST - 1);
  localparam logic [SLOT_W-1:0] SLOT_LOAD = SLOT_W'(CPU_MIN_SLOTS);

  arb_state_t        state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              aux_rvalid_q, aux_rvalid_d;
  logic [DATA_W-1:0] aux_data_read_q, aux_data_read_d;

  always_comb begin
    state_d         = state_q;
    slot_cnt_d      = slot_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    rd_pend_d       = 1'b0;
    aux_rvalid_d    = rd_pend_q;
    aux_data_read_d = aux_data_read_q;
    // Synchronous RAM: data for a read granted last cycle is on mem_data_read now.
    if (rd_pend_q) aux_data_read_d = bus.mem_data_read;

    case (state_q)
      ARB_CPU: begin
        if (slot_cnt_q != '0) slot_cnt_d = slot_cnt_q - SLOT_W'(1);
        // A request arriving as the fairness window expires switches next cycle.
        if (bus.aux_req && (slot_cnt_d == '0)) state_d = ARB_SWITCH;
      end
      ARB_SWITCH: state_d = ARB_AUX;
      ARB_AUX: begin
        if (!bus.aux_req) begin
          state_d    = ARB_CPU;
          slot_cnt_d = SLOT_LOAD;
          beat_cnt_d = '0;
        end else begin
          rd_pend_d = (bus.aux_data_we == '0);
          if (beat_cnt_q == BEAT_LAST) begin
            state_d    = ARB_CPU;
            slot_cnt_d = SLOT_LOAD;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ARB_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ARB_CPU;
      slot_cnt_q      <= '0;
      beat_cnt_q      <= '0;
      rd_pend_q       <= 1'b0;
      aux_rvalid_q    <= 1'b0;
      aux_data_read_q <= '0;
    end else begin
      state_q         <= state_d;
      slot_cnt_q      <= slot_cnt_d;
      beat_cnt_q      <= beat_cnt_d;
      rd_pend_q       <= rd_pend_d;
      aux_rvalid_q    <= aux_rvalid_d;
      aux_data_read_q <= aux_data_read_d;
    end
  end

  // Bus mux: SWITCH keeps the CPU address (its last read returns) but blocks writes.
  always_comb begin
    bus.mem_address    = bus.cpu_address;
    bus.mem_data_write = bus.cpu_data_write;
    bus.mem_data_we    = bus.cpu_data_we;
    case (state_q)
      ARB_SWITCH: bus.mem_data_we = '0;
      ARB_AUX: begin
        bus.mem_address    = bus.aux_address;
        bus.mem_data_write = bus.aux_data_write;
        bus.mem_data_we    = bus.aux_req ? bus.aux_data_we : '0;
      end
      default: ;
    endcase
  end

  assign bus.stall         = (state_q != ARB_CPU);
  assign bus.aux_gnt       = (state_q == ARB_AUX) && bus.aux_req;
  assign bus.cpu_data_read = bus.mem_data_read;
  assign bus.aux_data_read = aux_data_read_q;
  assign bus.aux_rvalid    = aux_rvalid_q;

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Self-checking bench for hfrv_mem_arbiter: vector table, directed corner cases
// and randomized traffic against an ownership-level reference model.
module tb_hfrv_mem_arbiter;
  import hfrv_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hfrv_mem_arbiter_if bus();

  hfrv_mem_arbiter #(.AUX_MAX_BURST(8), .CPU_MIN_SLOTS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM model, word index from address bits [11:2]
  logic [31:0] ram [0:1023];
  logic        clr_ram;
  logic        poke;
  logic [9:0]  poke_idx;
  logic [31:0] poke_val;

  always @(posedge clk) begin
    if (clr_ram) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_data_we[b]) ram[bus.mem_address[11:2]][8*b +: 8] <= bus.mem_data_write[8*b +: 8];
      if (poke) ram[poke_idx] <= poke_val;
    end
    bus.mem_data_read <= ram[bus.mem_address[11:2]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cpu_address = '0; bus.cpu_data_write = '0; bus.cpu_data_we = '0;
    bus.aux_req = 1'b0; bus.aux_address = '0; bus.aux_data_write = '0; bus.aux_data_we = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_ram = 1'b1; poke = 1'b0; poke_idx = '0; poke_val = '0;
    drive_idle();
    @(posedge clk); #1;
    clr_ram = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] aaddr;
    logic [31:0] awd;
    logic [3:0]  awe;
    logic [3:0]  cwe;
    logic        e_stall;
    logic        e_gnt;
    logic        e_aux;
    logic [3:0]  e_we;
    logic        e_rv;
  } vec_t;

  vec_t vt [13];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table starting from a fresh CPU state with an empty fairness window.
    vt[0]  = '{1'b0, 32'h0,        32'h0,        4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
    vt[1]  = '{1'b1, 32'h40000010, 32'hDEADBEEF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
    vt[2]  = '{1'b1, 32'h40000010, 32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[3]  = '{1'b1, 32'h40000010, 32'hDEADBEEF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0};
    vt[4]  = '{1'b0, 32'h0,        32'h0,        4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
    vt[5]  = '{1'b0, 32'h0,        32'h0,        4'h0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0};
    vt[6]  = '{1'b1, 32'h100,      32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[7]  = '{1'b1, 32'h100,      32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[8]  = '{1'b1, 32'h100,      32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[9]  = '{1'b1, 32'h100,      32'h0,        4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    vt[10] = '{1'b1, 32'h100,      32'h0,        4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0};
    vt[11] = '{1'b0, 32'h0,        32'h0,        4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0};
    vt[12] = '{1'b0, 32'h0,        32'h0,        4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("reset_state", {bus.stall, bus.aux_gnt, bus.aux_rvalid, bus.aux_data_read},
        {1'b0, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    poke = 1'b1; poke_idx = 10'h040; poke_val = 32'h12345678;
    @(posedge clk); #1;
    poke = 1'b0;

    for (int i = 0; i < 13; i++) begin
      bus.cpu_address = 32'h200; bus.cpu_data_write = 32'hA5; bus.cpu_data_we = vt[i].cwe;
      bus.aux_req = vt[i].req; bus.aux_address = vt[i].aaddr;
      bus.aux_data_write = vt[i].awd; bus.aux_data_we = vt[i].awe;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), {bus.stall, bus.aux_gnt, bus.aux_rvalid, bus.mem_data_we},
          {vt[i].e_stall, vt[i].e_gnt, vt[i].e_rv, vt[i].e_we});
      chk($sformatf("vec%0d_bus", i), {bus.mem_address, bus.mem_data_write},
          vt[i].e_aux ? {vt[i].aaddr, vt[i].awd} : {32'h200, 32'hA5});
      if (vt[i].e_rv) chk("aux_read_data", bus.aux_data_read, 32'h12345678);
      @(posedge clk); #1;
    end
    drive_idle();
    chk("cpu_write_kept", ram[10'h080], 32'h000000A5);
    chk("aux_write_done", ram[10'h004], 32'hDEADBEEF);

    // Burst cap and fairness window with aux_req held for 20 cycles
    begin
      logic st [20];
      logic gn [20];
      logic [3:0] we [20];
      int g0, k, run, nfree;
      do_reset();
      bus.aux_req = 1'b1; bus.aux_address = 32'h300; bus.aux_data_write = 32'h1; bus.aux_data_we = 4'hF;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        st[c] = bus.stall; gn[c] = bus.aux_gnt; we[c] = bus.mem_data_we;
        @(posedge clk); #1;
      end
      drive_idle();
      g0 = 0;
      while (g0 < 19 && !gn[g0]) g0++;
      k = g0; run = 0;
      while (k < 20 && gn[k]) begin run++; k++; end
      nfree = 0;
      while (k < 20 && !st[k]) begin nfree++; k++; end
      chk("burst_grants", run, 8);
      chk("fair_cpu_cycles", nfree, 4);
      if (k < 20) chk("switch_after_fair", {st[k], gn[k], we[k]}, {1'b1, 1'b0, 4'h0});
      else chk("switch_after_fair_reached", k, 19);
    end

    // Asynchronous reset in the middle of an aux read burst
    begin
      int n;
      logic rv;
      do_reset();
      bus.cpu_address = 32'h33330000;
      bus.aux_req = 1'b1; bus.aux_address = 32'h40000020; bus.aux_data_we = 4'h0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.aux_gnt && n < 10);
      chk("rst_gnt_seen", bus.aux_gnt, 1'b1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("rst_async", {bus.stall, bus.aux_gnt, bus.mem_address}, {1'b0, 1'b0, 32'h33330000});
      bus.aux_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      rv = 1'b0;
      for (int c = 0; c < 3; c++) begin @(negedge clk); rv |= bus.aux_rvalid; end
      chk("rst_rvalid_dropped", rv, 1'b0);
      @(posedge clk); #1;
    end

    // Idle: 100 cycles without aux requests
    do_reset();
    for (int c = 0; c < 100; c++) begin
      bus.cpu_address = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      bus.cpu_data_write = $urandom;
      bus.cpu_data_we = 4'($urandom);
      bus.aux_address = $urandom; bus.aux_data_write = $urandom; bus.aux_data_we = 4'($urandom);
      @(negedge clk);
      chk("idle_ctl", {bus.stall, bus.mem_data_we, bus.mem_address}, {1'b0, bus.cpu_data_we, bus.cpu_address});
      chk("idle_wdata", bus.mem_data_write, bus.cpu_data_write);
      @(posedge clk); #1;
    end

    // Randomized traffic against an ownership-level reference model
    begin
      logic [31:0] mmem [0:1023];
      int own, fair, beats;                 // own: 0 CPU, 1 handover, 2 aux
      logic rv1, rv2, last_gnt;
      logic [31:0] rd1, rd2;
      logic a_req;
      logic [31:0] a_addr, a_wd;
      logic [3:0] a_we;
      logic e_stall, e_gnt;
      logic [31:0] e_addr, e_wd;
      logic [3:0] e_we;
      int bad;
      do_reset();
      for (int i = 0; i < 1024; i++) mmem[i] = '0;
      own = 0; fair = 0; beats = 0; rv1 = 0; rv2 = 0; rd1 = '0; rd2 = '0;
      last_gnt = 0; a_req = 0; a_addr = '0; a_wd = '0; a_we = '0;
      for (int c = 0; c < 400; c++) begin
        if (a_req && last_gnt) a_req = 1'b0;
        if (!a_req && $urandom_range(0, 2) != 0) begin
          a_req = 1'b1;
          a_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
          a_wd = $urandom;
          a_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        end
        bus.aux_req = a_req; bus.aux_address = a_addr; bus.aux_data_write = a_wd; bus.aux_data_we = a_we;
        bus.cpu_address = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        bus.cpu_data_write = $urandom;
        bus.cpu_data_we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        @(negedge clk);
        e_stall = (own != 0);
        e_gnt = (own == 2) && a_req;
        e_addr = (own == 2) ? a_addr : bus.cpu_address;
        e_wd = (own == 2) ? a_wd : bus.cpu_data_write;
        e_we = (own == 0) ? bus.cpu_data_we : (e_gnt ? a_we : 4'h0);
        chk("rand_ctl", {e_stall ^ bus.stall, e_gnt ^ bus.aux_gnt, bus.mem_data_we}, {2'b00, e_we});
        chk("rand_bus", {bus.mem_address, bus.mem_data_write}, {e_addr, e_wd});
        chk("rand_rvalid", bus.aux_rvalid, rv2);
        if (rv2) chk("rand_rdata", bus.aux_data_read, rd2);
        rv2 = rv1; rd2 = rd1;
        rv1 = e_gnt && (a_we == 4'h0);
        rd1 = mmem[e_addr[11:2]];
        for (int b = 0; b < 4; b++) if (e_we[b]) mmem[e_addr[11:2]][8*b +: 8] = e_wd[8*b +: 8];
        if (own == 0) begin
          if (fair > 0) fair--;
          if (a_req && fair == 0) own = 1;
        end else if (own == 1) begin
          own = 2;
        end else if (!a_req || beats + 1 == 8) begin
          own = 0; fair = 4; beats = 0;
        end else begin
          beats++;
        end
        last_gnt = e_gnt;
        @(posedge clk); #1;
      end
      drive_idle();
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (ram[i] !== mmem[i]) bad++;
      chk("rand_mem_image", bad, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
